// File: rtl/demux4_reg_if.sv
// Handshake/bus bundle for demux4_reg: one producer stream in, four held channels out.
// The master side drives stimulus and consumer readiness; the slave side is the demux.
interface demux4_reg_if #(
   parameter int unsigned WIDTH = 8
);
   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       sel;
   logic             auto_sel;
   logic [1:0]       cur_tgt;
   logic [WIDTH-1:0] y0;
   logic [WIDTH-1:0] y1;
   logic [WIDTH-1:0] y2;
   logic [WIDTH-1:0] y3;
   logic [3:0]       y_valid;
   logic [3:0]       y_ready;

   modport master (
      output in_data, in_valid, sel, auto_sel, y_ready,
      input  in_ready, cur_tgt, y0, y1, y2, y3, y_valid
   );

   modport slave (
      input  in_data, in_valid, sel, auto_sel, y_ready,
      output in_ready, cur_tgt, y0, y1, y2, y3, y_valid
   );
endinterface

// File: rtl/demux4_reg.sv
// Registered 1-to-4 demultiplexer: each channel owns a one-word holding register,
// steering is by sel or by a round-robin pointer that only advances on accepted words.
module demux4_reg #(
   parameter int unsigned WIDTH = 8
) (
   input logic          clk,
   input logic          rst_n,
   demux4_reg_if.slave  bus
);

   logic [3:0][WIDTH-1:0] data_q;
   logic [3:0][WIDTH-1:0] data_d;
   logic [3:0]            y_valid_q;
   logic [3:0]            y_valid_d;
   logic [1:0]            rr_ptr_q;
   logic [1:0]            rr_ptr_d;

   logic [1:0]            tgt;
   logic                  in_ready;
   logic                  accept;

   // Target is free if empty or being drained this cycle, giving 1 word/cycle pass-through.
   always_comb begin
      tgt      = bus.auto_sel ? rr_ptr_q : bus.sel;
      in_ready = ~y_valid_q[tgt] | bus.y_ready[tgt];
      accept   = bus.in_valid & in_ready;
   end

   always_comb begin
      data_d    = data_q;
      y_valid_d = y_valid_q & ~bus.y_ready;
      rr_ptr_d  = rr_ptr_q;
      if (accept) begin
         data_d[tgt]    = bus.in_data;
         y_valid_d[tgt] = 1'b1;
         if (bus.auto_sel) begin
            rr_ptr_d = rr_ptr_q + 2'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q    <= '0;
         y_valid_q <= '0;
         rr_ptr_q  <= '0;
      end else begin
         data_q    <= data_d;
         y_valid_q <= y_valid_d;
         rr_ptr_q  <= rr_ptr_d;
      end
   end

   assign bus.in_ready = in_ready;
   assign bus.cur_tgt  = tgt;
   assign bus.y0       = data_q[0];
   assign bus.y1       = data_q[1];
   assign bus.y2       = data_q[2];
   assign bus.y3       = data_q[3];
   assign bus.y_valid  = y_valid_q;

endmodule

// File: tb/tb_demux4_reg.sv
// Self-checking bench for demux4_reg: directed vector table, hand-written reset/drain
// sequences, then randomized traffic against a per-channel queue model.
module tb_demux4_reg;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   demux4_reg_if #(.WIDTH(8)) bus ();

   demux4_reg #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] data;
      logic       valid;
      logic [1:0] sel;
      logic       auto_sel;
      logic [3:0] y_ready;
      logic       exp_ready;
      logic [1:0] exp_tgt;
      logic [3:0] exp_valid;
      logic [7:0] exp_y;
   } vec_t;

   vec_t tbl[16];

   // Reference model: each channel is a queue of at most one word.
   logic [7:0] mq[4][$];
   logic [7:0] m_last[4];
   int         m_ptr;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] get_y(input int k);
      case (k)
         0:       return bus.y0;
         1:       return bus.y1;
         2:       return bus.y2;
         default: return bus.y3;
      endcase
   endfunction

   task automatic drive(input logic [7:0] d, input logic v, input logic [1:0] s,
                        input logic a, input logic [3:0] r);
      bus.in_data  = d;
      bus.in_valid = v;
      bus.sel      = s;
      bus.auto_sel = a;
      bus.y_ready  = r;
   endtask

   task automatic model_reset();
      for (int k = 0; k < 4; k++) begin
         mq[k].delete();
         m_last[k] = 8'h00;
      end
      m_ptr = 0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks = 0;
      n_fail   = 0;
      drive(8'h00, 1'b0, 2'd0, 1'b0, 4'h0);
      rst_n = 1'b0;
      #2;
      chk("reset_y_valid", 32'(bus.y_valid), 32'h0);
      chk("reset_in_ready", 32'(bus.in_ready), 32'h1);
      for (int k = 0; k < 4; k++) chk("reset_y", 32'(get_y(k)), 32'h0);
      bus.sel = 2'd2;
      #1;
      chk("reset_cur_tgt_manual", 32'(bus.cur_tgt), 32'd2);
      bus.auto_sel = 1'b1;
      #1;
      chk("reset_cur_tgt_auto", 32'(bus.cur_tgt), 32'd0);
      drive(8'h00, 1'b0, 2'd0, 1'b0, 4'h0);
      #8 rst_n = 1'b1;

      //           data   v     sel   auto  yrdy     rdy   tgt   valid     y[tgt]
      tbl[0]  = '{8'h01, 1'b1, 2'd0, 1'b0, 4'b0000, 1'b1, 2'd0, 4'b0001, 8'h01};
      tbl[1]  = '{8'h02, 1'b1, 2'd1, 1'b0, 4'b0000, 1'b1, 2'd1, 4'b0011, 8'h02};
      tbl[2]  = '{8'h04, 1'b1, 2'd2, 1'b0, 4'b0000, 1'b1, 2'd2, 4'b0111, 8'h04};
      tbl[3]  = '{8'h08, 1'b1, 2'd3, 1'b0, 4'b0000, 1'b1, 2'd3, 4'b1111, 8'h08};
      tbl[4]  = '{8'hAA, 1'b1, 2'd2, 1'b0, 4'b0000, 1'b0, 2'd2, 4'b1111, 8'h04};
      tbl[5]  = '{8'hAA, 1'b1, 2'd2, 1'b0, 4'b0100, 1'b1, 2'd2, 4'b1111, 8'hAA};
      tbl[6]  = '{8'h10, 1'b1, 2'd0, 1'b1, 4'b1111, 1'b1, 2'd0, 4'b0001, 8'h10};
      tbl[7]  = '{8'h11, 1'b1, 2'd0, 1'b1, 4'b1111, 1'b1, 2'd1, 4'b0010, 8'h11};
      tbl[8]  = '{8'h12, 1'b1, 2'd0, 1'b1, 4'b1111, 1'b1, 2'd2, 4'b0100, 8'h12};
      tbl[9]  = '{8'h13, 1'b1, 2'd0, 1'b1, 4'b1111, 1'b1, 2'd3, 4'b1000, 8'h13};
      tbl[10] = '{8'h14, 1'b1, 2'd0, 1'b1, 4'b1111, 1'b1, 2'd0, 4'b0001, 8'h14};
      tbl[11] = '{8'h20, 1'b1, 2'd1, 1'b0, 4'b0000, 1'b1, 2'd1, 4'b0011, 8'h20};
      tbl[12] = '{8'h21, 1'b1, 2'd0, 1'b1, 4'b0000, 1'b0, 2'd1, 4'b0011, 8'h20};
      tbl[13] = '{8'h21, 1'b1, 2'd0, 1'b1, 4'b0000, 1'b0, 2'd1, 4'b0011, 8'h20};
      tbl[14] = '{8'h21, 1'b1, 2'd3, 1'b0, 4'b0000, 1'b1, 2'd3, 4'b1011, 8'h21};
      tbl[15] = '{8'h22, 1'b0, 2'd0, 1'b1, 4'b0000, 1'b0, 2'd1, 4'b1011, 8'h20};

      for (int i = 0; i < 16; i++) begin
         drive(tbl[i].data, tbl[i].valid, tbl[i].sel, tbl[i].auto_sel, tbl[i].y_ready);
         #2;
         chk("vec_in_ready", 32'(bus.in_ready), 32'(tbl[i].exp_ready));
         chk("vec_cur_tgt", 32'(bus.cur_tgt), 32'(tbl[i].exp_tgt));
         @(posedge clk);
         #1;
         chk("vec_y_valid", 32'(bus.y_valid), 32'(tbl[i].exp_valid));
         chk("vec_y_tgt", 32'(get_y(int'(tbl[i].exp_tgt))), 32'(tbl[i].exp_y));
      end

      // Asynchronous reset between edges with y_valid=1011.
      #2 rst_n = 1'b0;
      #1;
      chk("async_y_valid", 32'(bus.y_valid), 32'h0);
      for (int k = 0; k < 4; k++) chk("async_y", 32'(get_y(k)), 32'h0);
      chk("async_cur_tgt", 32'(bus.cur_tgt), 32'd0);
      chk("async_in_ready", 32'(bus.in_ready), 32'h1);
      #2 rst_n = 1'b1;
      drive(8'h55, 1'b1, 2'd2, 1'b1, 4'b0000);
      #1;
      chk("post_reset_tgt", 32'(bus.cur_tgt), 32'd0);
      @(posedge clk);
      #1;
      chk("post_reset_y0", 32'(bus.y0), 32'h55);
      chk("post_reset_valid", 32'(bus.y_valid), 32'b0001);

      // Independent drain of ch3 only.
      drive(8'h66, 1'b1, 2'd3, 1'b0, 4'b0000);
      @(posedge clk);
      #1;
      chk("drain_setup_valid", 32'(bus.y_valid), 32'b1001);
      drive(8'h00, 1'b0, 2'd0, 1'b0, 4'b1000);
      @(posedge clk);
      #1;
      chk("drain_valid", 32'(bus.y_valid), 32'b0001);
      chk("drain_y0", 32'(bus.y0), 32'h55);
      chk("drain_y3_kept", 32'(bus.y3), 32'h66);
      drive(8'h00, 1'b0, 2'd0, 1'b0, 4'b0000);
      @(posedge clk);
      #1;
      chk("drain_idle_valid", 32'(bus.y_valid), 32'b0001);

      // Randomized traffic against the queue model, from a fresh reset.
      rst_n = 1'b0;
      #2 rst_n = 1'b1;
      model_reset();
      for (int cyc = 0; cyc < 400; cyc++) begin
         logic [7:0] d;
         logic       v;
         logic [1:0] s;
         logic       a;
         logic [3:0] r;
         int         t;
         bit         rdy;
         d = 8'($urandom);
         v = ($urandom_range(0, 3) != 0);
         s = 2'($urandom);
         a = ($urandom_range(0, 2) != 0);
         r = 4'($urandom);
         drive(d, v, s, a, r);
         t   = a ? m_ptr : int'(s);
         rdy = (mq[t].size() == 0) || r[t];
         #2;
         chk("rand_cur_tgt", 32'(bus.cur_tgt), 32'(t));
         chk("rand_in_ready", 32'(bus.in_ready), 32'(rdy));
         @(posedge clk);
         for (int k = 0; k < 4; k++) begin
            if (r[k] && mq[k].size() != 0) void'(mq[k].pop_front());
         end
         if (v && rdy) begin
            mq[t].push_back(d);
            m_last[t] = d;
            if (a) m_ptr = (m_ptr + 1) % 4;
         end
         #1;
         for (int k = 0; k < 4; k++) begin
            chk("rand_y_valid", 32'(bus.y_valid[k]), 32'(mq[k].size() != 0));
            chk("rand_y", 32'(get_y(k)), 32'(m_last[k]));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/demux4_reg.md
Name: demux4_reg

Overview:
- Registered 1-to-4 demultiplexer with valid/ready handshakes: the distribution counterpart of the team's 4:1 8-bit selector.
- One input stream is steered to one of four output channels. Steering is either by explicit `sel` or by an internal round-robin pointer.
- Each channel has a one-entry holding register, so a stalled consumer blocks only its own channel.
- Sits between a single producer and four independent consumers.

Parameters:
- WIDTH, 8, data width of input and each output channel.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_data  input  WIDTH  input data word.
- in_valid  input  1  producer offers in_data.
- in_ready  output  1  block accepts in_data this cycle.
- sel  input  2  manual target channel (0..3); used when auto_sel=0.
- auto_sel  input  1  1 = round-robin steering, 0 = steering by sel.
- cur_tgt  output  2  channel the current input would be routed to.
- y0, y1, y2, y3  output  WIDTH each  channel holding registers.
- y_valid  output  4  bit k = channel k holds a valid word.
- y_ready  input  4  bit k = consumer k takes y_k this cycle.

Behaviour:
- Target selection (combinational):
  - tgt = auto_sel ? rr_ptr : sel.
  - cur_tgt = tgt.
- in_ready = ~y_valid[tgt] | y_ready[tgt].
  - Combinational path from y_ready and sel/auto_sel to in_ready is intended.
- Accept = in_valid & in_ready, sampled at the rising edge.
  - On accept: y_tgt <= in_data and y_valid[tgt] <= 1.
  - Latency is 1 cycle: the word is visible on y_tgt the cycle after acceptance.
- Drain: channel k transfers when y_valid[k] & y_ready[k]; y_valid[k] then clears next cycle.
  - Exception: if a new accept to channel k occurs in the same cycle, y_valid[k] stays 1 and y_k loads the new word.
  - This gives 1 word/cycle pass-through on a channel whose consumer is always ready.
- Stall: while y_valid[k]=1 and y_ready[k]=0, y_k and y_valid[k] hold stable.
  - Input to channel k is refused (in_ready=0 when tgt=k).
  - Other channels continue to drain independently.
- Channels with no accept and no drain hold their value.
  - y_k keeps its last data after draining; consumers must qualify y_k with y_valid[k].
- Round-robin pointer rr_ptr (2-bit):
  - Increments by 1 on each accept while auto_sel=1, wrapping 3 -> 0.
  - Does not change when auto_sel=0 or when no accept occurs.
  - A refused word (target channel full) does not advance the pointer; the producer retries the same channel.
- Mode switch: auto_sel may change on any cycle and takes effect combinationally.
  - rr_ptr keeps its value across manual periods and resumes from it.
- in_valid=0 produces no state change except channel drains.
- Reset (asynchronous, rst_n=0):
  - y0..y3 = 0, y_valid = 4'b0000, rr_ptr = 0.
  - As a result, in_ready = 1 and cur_tgt = sel (manual) or 0 (auto).
  - Reset mid-operation discards all held words immediately.
  - The first accept after deassertion occurs on the first rising edge with rst_n=1.
- No counters overflow; the pointer wrap is the only arithmetic.

Test Plan:
- Manual fill: after reset, with y_ready=0, send 8'h01/sel=0, 8'h02/sel=1, 8'h04/sel=2, 8'h08/sel=3 on consecutive cycles.
  - Expect y0..y3 = 01,02,04,08 and y_valid=1111.
  - Expect in_ready=1 throughout.
- Backpressure: channel 2 full and y_ready[2]=0, offer 8'hAA with sel=2.
  - Expect in_ready=0; y2 holds 04.
  - Raise y_ready[2]: the same cycle accepts AA, and y2=AA next cycle with y_valid[2] still 1.
- Round-robin: auto_sel=1, all y_ready=1, stream 10,11,12,13,14.
  - Expect routing to ch0,1,2,3,0 with cur_tgt sequence 0,1,2,3,0.
  - Each word appears on its channel one cycle after acceptance.
- RR stall: auto_sel=1, rr_ptr=1, ch1 full and not ready, in_valid=1.
  - Expect in_ready=0 and rr_ptr stays 1.
  - Switch auto_sel=0 with sel=3: word accepted to y3, and rr_ptr is still 1.
- Async reset: with y_valid=1011, assert rst_n=0 between clock edges.
  - Expect y_valid=0000 and y0..y3=0 immediately, without waiting for a clock edge.
  - After release, the first accept lands 8'h55 in ch0 under auto mode.
- Independent drain: ch0 and ch3 full, pulse y_ready=4'b1000 for one cycle.
  - Expect y_valid 1001 -> 0001, with y0 unchanged.
